// File: rtl/top_pkg.sv
// ---------------------------------------------------------------------------
// top_pkg
// Shared types and sizing helpers for the ping-pong reader slice.
//   TOP_CHUNK_SIZE       : elements per core per beat
//   pp_rd_state_t        : reader FSM states
//   calc_module_width()  : beat width in bits from element width and core counts
//   calc_depth()         : words per bank tile from producer geometry
// ---------------------------------------------------------------------------
package top_pkg;

  localparam int TOP_CHUNK_SIZE = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    DRAIN   = 2'd2,
    RELEASE = 2'd3
  } pp_rd_state_t;

  function automatic int calc_module_width(input int width, input int cores_a,
                                           input int cores_b);
    return width * TOP_CHUNK_SIZE * cores_a * cores_b;
  endfunction

  function automatic int calc_depth(input int col_x, input int total_input_w);
    return col_x * total_input_w;
  endfunction

  // Sizes for the default parameter set, handy for benches and wrappers
  localparam int DEFAULT_MODULE_WIDTH = calc_module_width(16, 2, 1);
  localparam int DEFAULT_DEPTH        = calc_depth(16, 2);

endpackage

// File: rtl/pp_rd_fifo.sv
// ---------------------------------------------------------------------------
// pp_rd_fifo
// Two-entry output FIFO between the BRAM read data and the consumer stream.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid_i/in_ready_o : push handshake
//   in_data_i             : pushed word
//   out_valid_o/out_ready_i : pop handshake
//   out_data_o            : head word (held stable until popped)
//   count_o               : number of stored words (0..2)
// ---------------------------------------------------------------------------
module pp_rd_fifo #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic [1:0]    count_o
);

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    count_q;
  logic [1:0]    count_d;
  logic          push;
  logic          pop;

  // A full FIFO may still accept a word in the same cycle its head leaves
  always_comb begin
    out_valid_o = (count_q != 2'd0);
    in_ready_o  = (count_q != 2'd2) || out_ready_i;
    push        = in_valid_i && in_ready_o;
    pop         = out_valid_o && out_ready_i;
    out_data_o  = mem_q[rd_ptr_q];
    count_o     = count_q;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the stream data reads as zero afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ping_pong_reader.sv
// ---------------------------------------------------------------------------
// ping_pong_reader
// Drains two ping-pong BRAM banks alternately (bank 0 first) into a
// valid/ready stream, releasing each bank back to the writer once its tile
// has been fully accepted downstream.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   bank_full[1:0]           : bank i holds a complete tile
//   bank_release[1:0]        : one-cycle pulse, bank i may be refilled
//   rd_en[1:0], rd_addr      : BRAM read enables and shared read address
//   bank0_dout, bank1_dout   : BRAM read data, one-cycle latency
//   out_data, out_valid, out_last, out_ready : consumer stream
//   active_bank_rd           : bank currently owned by the reader
// Build option:
//   PP_RD_TRANSPOSE_EN : column-major address order (row index fastest)
// ---------------------------------------------------------------------------
module ping_pong_reader
  import top_pkg::*;
#(
  parameter  int WIDTH         = 16,
  parameter  int NUM_CORES_A   = 2,
  parameter  int NUM_CORES_B   = 1,
  parameter  int COL_X         = 16,
  parameter  int TOTAL_INPUT_W = 2,
  localparam int MODULE_WIDTH  = calc_module_width(WIDTH, NUM_CORES_A, NUM_CORES_B),
  localparam int DEPTH         = calc_depth(COL_X, TOTAL_INPUT_W),
  localparam int ADDR_WIDTH    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              bank_full,
  output logic [1:0]              bank_release,
  output logic [1:0]              rd_en,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [MODULE_WIDTH-1:0] bank0_dout,
  input  logic [MODULE_WIDTH-1:0] bank1_dout,
  output logic [MODULE_WIDTH-1:0] out_data,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    active_bank_rd
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
`ifdef PP_RD_TRANSPOSE_EN
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(TOTAL_INPUT_W - 1);
  localparam logic [ADDR_WIDTH-1:0] COL_STEP = ADDR_WIDTH'(COL_X);
`endif

  pp_rd_state_t            state_q, state_d;
  logic                    active_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
`ifdef PP_RD_TRANSPOSE_EN
  logic [ADDR_WIDTH-1:0]   row_q;
  logic [ADDR_WIDTH-1:0]   col_q;
`endif
  logic                    inflight_q;
  logic                    inflight_last_q;

  logic                    fifo_in_ready;
  logic                    fifo_out_valid;
  logic [1:0]              fifo_count;
  logic [MODULE_WIDTH:0]   fifo_in_data;
  logic [MODULE_WIDTH:0]   fifo_out_data;
  logic [2:0]              credit_use;
  logic                    pop;
  logic                    issue;
  logic                    issue_last;

  // Words stored plus the one in flight, minus the one leaving now, must stay
  // below two so the captured read data always has a FIFO slot waiting.
  always_comb begin
    pop        = fifo_out_valid && out_ready;
    credit_use = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    issue      = (state_q == READ) && (credit_use < 3'd2) && fifo_in_ready;
    issue_last = issue && (idx_q == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bank_full[active_q]) state_d = READ;
      READ:    if (issue_last) state_d = DRAIN;
      DRAIN:   if (pop && fifo_out_data[MODULE_WIDTH]) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en        = 2'b00;
    bank_release = 2'b00;
    rd_en[active_q] = issue;
    if (state_q == RELEASE) bank_release[active_q] = 1'b1;
  end

  // Address walker; it rewinds to zero as soon as the final read is issued
  // so the next tile (or an idle reader) presents address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q        <= 1'b0;
      idx_q           <= '0;
      addr_q          <= '0;
`ifdef PP_RD_TRANSPOSE_EN
      row_q           <= '0;
      col_q           <= '0;
`endif
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= issue_last;
      if (issue) begin
        if (issue_last) begin
          idx_q  <= '0;
          addr_q <= '0;
`ifdef PP_RD_TRANSPOSE_EN
          row_q  <= '0;
          col_q  <= '0;
`endif
        end else begin
          idx_q <= idx_q + ADDR_ONE;
`ifdef PP_RD_TRANSPOSE_EN
          if (row_q == ROW_LAST) begin
            row_q  <= '0;
            col_q  <= col_q + ADDR_ONE;
            addr_q <= col_q + ADDR_ONE;
          end else begin
            row_q  <= row_q + ADDR_ONE;
            addr_q <= addr_q + COL_STEP;
          end
`else
          addr_q <= addr_q + ADDR_ONE;
`endif
        end
      end
      if (state_q == RELEASE) active_q <= ~active_q;
    end
  end

  // The active bank cannot change between a read and its capture, so the
  // mux select is safe to take from the current owner.
  assign fifo_in_data = {inflight_last_q, (active_q ? bank1_dout : bank0_dout)};

  pp_rd_fifo #(
    .DW(MODULE_WIDTH + 1)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (inflight_q),
    .in_ready_o  (fifo_in_ready),
    .in_data_i   (fifo_in_data),
    .out_valid_o (fifo_out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (fifo_out_data),
    .count_o     (fifo_count)
  );

  assign out_data       = fifo_out_data[MODULE_WIDTH-1:0];
  assign out_valid      = fifo_out_valid;
  assign out_last       = fifo_out_valid && fifo_out_data[MODULE_WIDTH];
  assign rd_addr        = addr_q;
  assign active_bank_rd = active_q;

endmodule

// File: tb/tb_ping_pong_reader.sv
// ---------------------------------------------------------------------------
// tb_ping_pong_reader
// Self-checking bench for ping_pong_reader with the default geometry
// (COL_X=16, TOTAL_INPUT_W=2, DEPTH=32). Two behavioural BRAM banks are
// filled with random words; a reference model predicts every accepted beat
// from the bank contents and the tile address order.
// Honours PP_RD_TRANSPOSE_EN for the expected address order.
// ---------------------------------------------------------------------------
module tb_ping_pong_reader;
  import top_pkg::*;

  localparam int WIDTH = 16;
  localparam int NCA   = 2;
  localparam int NCB   = 1;
  localparam int COLX  = 16;
  localparam int TIW   = 2;
  localparam int MW    = calc_module_width(WIDTH, NCA, NCB);
  localparam int DEPTH = COLX * TIW;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic [1:0]    bank_full;
  logic [1:0]    bank_release;
  logic [1:0]    rd_en;
  logic [AW-1:0] rd_addr;
  logic [MW-1:0] bank0Dout;
  logic [MW-1:0] bank1Dout;
  logic [MW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic          active_bank_rd;

  ping_pong_reader #(
    .WIDTH(WIDTH), .NUM_CORES_A(NCA), .NUM_CORES_B(NCB),
    .COL_X(COLX), .TOTAL_INPUT_W(TIW)
  ) dut (
    .clk(clk), .rst(rst), .bank_full(bank_full), .bank_release(bank_release),
    .rd_en(rd_en), .rd_addr(rd_addr), .bank0_dout(bank0Dout),
    .bank1_dout(bank1Dout), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .active_bank_rd(active_bank_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural BRAM banks with one-cycle read latency
  logic [MW-1:0] bankMem [2][DEPTH];
  initial begin
    bank0Dout = '0;
    bank1Dout = '0;
  end
  always @(posedge clk) begin
    if (rd_en[0]) bank0Dout <= bankMem[0][rd_addr];
    if (rd_en[1]) bank1Dout <= bankMem[1][rd_addr];
  end

  int errorCount = 0;
  int checkCount = 0;

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Expected address of the k-th read of a tile
  function automatic int addrOf(input int k);
`ifdef PP_RD_TRANSPOSE_EN
    return (k % TIW) * COLX + (k / TIW);
`else
    return k;
`endif
  endfunction

  task automatic fillBank(input int b);
    for (int a = 0; a < DEPTH; a++)
      for (int j = 0; j < MW / 32; j++)
        bankMem[b][a][j*32 +: 32] = $urandom;
  endtask

  // Reference model: which bank is being drained and how many beats so far
  int            modelBank = 0;
  int            beatIdx = 0;
  int            releaseCount = 0;
  logic          prevStall = 1'b0;
  logic [MW-1:0] prevData;
  logic          prevLast;
  logic [1:0]    otherMask;

  always @(negedge clk) begin
    if (rst) begin
      modelBank = 0;
      beatIdx   = 0;
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stallValid", out_valid, 1);
        checkOutput("stallData", out_data, prevData);
        checkOutput("stallLast", out_last, prevLast);
      end
      prevStall = out_valid && !out_ready;
      prevData  = out_data;
      prevLast  = out_last;
      checkOutput("activeBank", active_bank_rd, modelBank[0]);
      otherMask = modelBank[0] ? 2'b01 : 2'b10;
      checkOutput("otherRdEn", rd_en & otherMask, 0);
      if (out_valid && out_ready) begin
        if (beatIdx >= DEPTH) begin
          checkOutput("beatCount", beatIdx, DEPTH - 1);
        end else begin
          checkOutput("beatData", out_data, bankMem[modelBank][addrOf(beatIdx)]);
          checkOutput("beatLast", out_last, beatIdx == DEPTH - 1);
        end
        beatIdx++;
      end
      if (bank_release != 2'b00) begin
        checkOutput("releaseBank", bank_release, modelBank[0] ? 2'b10 : 2'b01);
        checkOutput("releaseBeats", beatIdx, DEPTH);
        modelBank    = modelBank ^ 1;
        beatIdx      = 0;
        releaseCount++;
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] full, input logic ready);
    @(posedge clk);
    #1;
    bank_full = full;
    out_ready = ready;
  endtask

  // Runs cycles with the chosen ready pattern (0 high, 1 toggle, 2 random)
  // until a release pulse appears or the budget expires.
  task automatic runUntilRelease(input string tag, input int mode, input int maxCycles);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < maxCycles && !seen; n++) begin
      @(posedge clk);
      #1;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (n % 2 == 0);
        default: out_ready = ($urandom % 4) != 0;
      endcase
      @(negedge clk);
      if (bank_release != 2'b00) seen = 1'b1;
    end
    checkOutput(tag, seen, 1);
  endtask

  int  gaps;
  int  gap;
  int  beats;
  bit  sawRead;

  initial begin
    rst       = 1'b1;
    bank_full = 2'b00;
    out_ready = 1'b0;
    fillBank(0);
    fillBank(1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstRdEn", rd_en, 0);
    checkOutput("rstAddr", rd_addr, 0);
    checkOutput("rstValid", out_valid, 0);
    checkOutput("rstLast", out_last, 0);
    checkOutput("rstData", out_data, 0);
    checkOutput("rstRelease", bank_release, 0);
    checkOutput("rstActive", active_bank_rd, 0);

    // Single tile from bank 0 with the consumer always ready
    applyStimulus(2'b01, 1'b1);
    @(negedge clk);
    checkOutput("idleRdEn", rd_en, 0);
    @(negedge clk);
    checkOutput("latRdEn", rd_en, 2'b01);
    checkOutput("firstAddr", rd_addr, addrOf(0));
    @(negedge clk);
    checkOutput("secondAddr", rd_addr, addrOf(1));
    checkOutput("latNoValid", out_valid, 0);
    @(negedge clk);
    checkOutput("latValid", out_valid, 1);
    gaps = 0;
    repeat (DEPTH - 1) begin
      @(negedge clk);
      if (!out_valid) gaps++;
    end
    checkOutput("bubbles", gaps, 0);
    runUntilRelease("tile0Release", 0, 10);
    @(negedge clk);
    checkOutput("activeAfter0", active_bank_rd, 1);
    checkOutput("idleAfter0", rd_en, 0);

    // Bank 1 with a toggling consumer
    fillBank(1);
    applyStimulus(2'b10, 1'b1);
    runUntilRelease("stallRelease", 1, 300);

    // Both banks full, random backpressure; bank_full drops mid-tile
    fillBank(0);
    fillBank(1);
    applyStimulus(2'b11, 1'b1);
    runUntilRelease("pairFirstRelease", 2, 400);
    gap = -1;
    for (int k = 1; k <= 4 && gap < 0; k++) begin
      @(posedge clk);
      #1;
      out_ready = ($urandom % 4) != 0;
      @(negedge clk);
      if (rd_en != 2'b00) begin
        gap = k;
        checkOutput("pairRdEn", rd_en, 2'b10);
      end
    end
    checkOutput("pairGapOk", (gap >= 1) && (gap <= 2), 1);
    applyStimulus(2'b00, 1'b1);
    runUntilRelease("pairSecondRelease", 2, 400);
    @(negedge clk);
    checkOutput("pairIdle", rd_en, 0);

    // Only the non-active bank full after reset: must stay idle
    @(posedge clk);
    #1;
    rst       = 1'b1;
    bank_full = 2'b10;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    sawRead = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (rd_en != 2'b00) sawRead = 1'b1;
    end
    checkOutput("wrongBankIdle", sawRead, 0);

    // Reset in the middle of a tile, then restart from bank 0 address 0
    fillBank(0);
    applyStimulus(2'b01, 1'b1);
    beats = 0;
    for (int n = 0; n < 60 && beats < 10; n++) begin
      @(negedge clk);
      if (out_valid && out_ready) beats++;
    end
    checkOutput("midBeats", beats, 10);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midRdEn", rd_en, 0);
    checkOutput("midAddr", rd_addr, 0);
    checkOutput("midData", out_data, 0);
    checkOutput("midValid", out_valid, 0);
    checkOutput("midLast", out_last, 0);
    checkOutput("midRelease", bank_release, 0);
    checkOutput("midActive", active_bank_rd, 0);
    @(negedge clk);
    checkOutput("restartRdEn", rd_en, 2'b01);
    checkOutput("restartAddr", rd_addr, 0);
    runUntilRelease("restartRelease", 0, 100);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
